micro_event_sequencer: RTL and testbench

- Sequences asynchronous control events into the microcode unit: exceptions, external interrupts, and escalation to double fault or shutdown.
- Generates the micro_reset / exc_init / exc_load pulse train that the microcode overlay expects.
- Waits for the read stage to drain before injection, and holds exc_eip and the vector stable until the microcode unit accepts the injected command.
- Sits between the exception/interrupt sources and the microcode block.

---
 rtl/micro_event_sequencer_pkg.sv | 44 ++++
 rtl/micro_event_sequencer_drain_timer.sv | 30 +++
 rtl/micro_event_sequencer.sv | 177 +++++++++++++++++
 tb/tb_micro_event_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_event_sequencer_pkg.sv
// Shared encodings for the micro event sequencer: FSM states, event source,
// the double-fault vector and the latched event record.
package micro_event_sequencer_pkg;

  localparam logic [2:0] MES_IDLE     = 3'd0;
  localparam logic [2:0] MES_FLUSH    = 3'd1;
  localparam logic [2:0] MES_DRAIN    = 3'd2;
  localparam logic [2:0] MES_INIT     = 3'd3;
  localparam logic [2:0] MES_LOAD     = 3'd4;
  localparam logic [2:0] MES_ACK      = 3'd5;
  localparam logic [2:0] MES_SHUTDOWN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = MES_IDLE,
    ST_FLUSH    = MES_FLUSH,
    ST_DRAIN    = MES_DRAIN,
    ST_INIT     = MES_INIT,
    ST_LOAD     = MES_LOAD,
    ST_ACK      = MES_ACK,
    ST_SHUTDOWN = MES_SHUTDOWN
  } mes_state_e;

  localparam logic [7:0] DF_VECTOR = 8'd8;

  localparam logic MES_SRC_EXC = 1'b0;
  localparam logic MES_SRC_INT = 1'b1;

  typedef enum logic {
    SRC_EXC = MES_SRC_EXC,
    SRC_INT = MES_SRC_INT
  } mes_src_e;

  typedef struct packed {
    logic [7:0]  vector;
    logic [31:0] eip;
    logic        push_error;
  } mes_event_t;

  // States in which a new exception strobe counts as nested and escalates.
  function automatic logic is_in_flight(input mes_state_e s);
    return (s == ST_FLUSH) || (s == ST_DRAIN) || (s == ST_INIT) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/micro_event_sequencer_drain_timer.sv
// Drain wait counter: clear, count enable, and a terminal-count flag that
// rises on the last permitted DRAIN cycle.
module micro_event_sequencer_drain_timer #(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments and the reset is
  // sampled on the clock edge (synchronous), so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(DRAIN_TIMEOUT - 1));

endmodule

// File: rtl/micro_event_sequencer.sv
// Sequences exceptions and external interrupts into the microcode unit as a
// micro_reset / exc_init / exc_load pulse train, with double-fault escalation.
module micro_event_sequencer
  import micro_event_sequencer_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic [7:0]  exc_req_vector,
  input  logic [31:0] exc_req_eip,
  input  logic        exc_req_push_error,
  input  logic        int_req,
  input  logic [7:0]  int_vector,
  input  logic [31:0] int_eip,
  input  logic        if_flag,
  input  logic        micro_busy,
  input  logic        rd_busy,
  input  logic        micro_ready,
  output logic        micro_reset,
  output logic        exc_init,
  output logic        exc_load,
  output logic [31:0] exc_eip,
  output logic [7:0]  exc_vector,
  output logic        exc_push_error,
  output logic        int_ack,
  output logic        drain_timeout,
  output logic        shutdown,
  output logic        seq_busy
);

  mes_state_e state;
  mes_src_e   src;
  mes_event_t ev;
  logic       df_active;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    if (state == ST_FLUSH) begin
      timer_clr = 1'b1;
    end else if (state == ST_DRAIN) begin
      timer_en = rd_busy && !timer_tc && !exc_req;
    end
  end

  micro_event_sequencer_drain_timer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_drain_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      src           <= SRC_EXC;
      ev            <= '0;
      df_active     <= 1'b0;
      micro_reset   <= 1'b0;
      exc_init      <= 1'b0;
      exc_load      <= 1'b0;
      int_ack       <= 1'b0;
      drain_timeout <= 1'b0;
      shutdown      <= 1'b0;
      seq_busy      <= 1'b0;
    end else begin
      micro_reset <= 1'b0;
      exc_init    <= 1'b0;
      exc_load    <= 1'b0;
      int_ack     <= 1'b0;

      if (exc_req && is_in_flight(state)) begin
        // Nested exception: first one becomes a double fault, the next one
        // is a triple fault and parks the sequencer until reset.
        if (df_active) begin
          state    <= ST_SHUTDOWN;
          shutdown <= 1'b1;
          seq_busy <= 1'b1;
        end else begin
          ev.vector     <= DF_VECTOR;
          ev.eip        <= exc_req_eip;
          ev.push_error <= 1'b1;
          src           <= SRC_EXC;
          df_active     <= 1'b1;
          state         <= ST_FLUSH;
          micro_reset   <= 1'b1;
          seq_busy      <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (exc_req) begin
              ev.vector     <= exc_req_vector;
              ev.eip        <= exc_req_eip;
              ev.push_error <= exc_req_push_error;
              src           <= SRC_EXC;
              state         <= ST_FLUSH;
              micro_reset   <= 1'b1;
              seq_busy      <= 1'b1;
            end else if (int_req && if_flag && !micro_busy) begin
              ev.vector     <= int_vector;
              ev.eip        <= int_eip;
              ev.push_error <= 1'b0;
              src           <= SRC_INT;
              state         <= ST_FLUSH;
              micro_reset   <= 1'b1;
              seq_busy      <= 1'b1;
            end
          end

          ST_FLUSH: begin
            state <= ST_DRAIN;
          end

          ST_DRAIN: begin
            if (!rd_busy) begin
              state    <= ST_INIT;
              exc_init <= 1'b1;
            end else if (timer_tc) begin
              drain_timeout <= 1'b1;
              state         <= ST_INIT;
              exc_init      <= 1'b1;
            end
          end

          ST_INIT: begin
            state    <= ST_LOAD;
            exc_load <= 1'b1;
          end

          ST_LOAD: begin
            if (micro_ready) begin
              state   <= ST_ACK;
              int_ack <= (src == SRC_INT);
            end else begin
              exc_load <= 1'b1;
            end
          end

          ST_ACK: begin
            df_active <= 1'b0;
            state     <= ST_IDLE;
            seq_busy  <= 1'b0;
          end

          ST_SHUTDOWN: begin
            shutdown <= 1'b1;
            seq_busy <= 1'b1;
          end

          default: begin
            state    <= ST_IDLE;
            seq_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign exc_eip        = ev.eip;
  assign exc_vector     = ev.vector;
  assign exc_push_error = ev.push_error;

endmodule

// File: tb/tb_micro_event_sequencer.sv
// Bench for micro_event_sequencer: directed scenarios with literal
// expectations plus random traffic compared every cycle to an event model.
module tb_micro_event_sequencer;

  localparam int DRAIN_TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        exc_req;
  logic [7:0]  exc_req_vector;
  logic [31:0] exc_req_eip;
  logic        exc_req_push_error;
  logic        int_req;
  logic [7:0]  int_vector;
  logic [31:0] int_eip;
  logic        if_flag;
  logic        micro_busy;
  logic        rd_busy;
  logic        micro_ready;
  logic        micro_reset;
  logic        exc_init;
  logic        exc_load;
  logic [31:0] exc_eip;
  logic [7:0]  exc_vector;
  logic        exc_push_error;
  logic        int_ack;
  logic        drain_timeout;
  logic        shutdown;
  logic        seq_busy;

  int total = 0;
  int bad   = 0;

  micro_event_sequencer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
    .CNT_W         (7)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .exc_req            (exc_req),
    .exc_req_vector     (exc_req_vector),
    .exc_req_eip        (exc_req_eip),
    .exc_req_push_error (exc_req_push_error),
    .int_req            (int_req),
    .int_vector         (int_vector),
    .int_eip            (int_eip),
    .if_flag            (if_flag),
    .micro_busy         (micro_busy),
    .rd_busy            (rd_busy),
    .micro_ready        (micro_ready),
    .micro_reset        (micro_reset),
    .exc_init           (exc_init),
    .exc_load           (exc_load),
    .exc_eip            (exc_eip),
    .exc_vector         (exc_vector),
    .exc_push_error     (exc_push_error),
    .int_ack            (int_ack),
    .drain_timeout      (drain_timeout),
    .shutdown           (shutdown),
    .seq_busy           (seq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] outs();
    return {micro_reset, exc_init, exc_load, int_ack, drain_timeout, shutdown,
            seq_busy, exc_push_error, exc_vector, exc_eip};
  endfunction

  // ---------------------------------------------------------------------
  // Event model: where the current event sits in the injection train
  // (flush, drain, init, load, ack) and what has been latched for it.
  // ---------------------------------------------------------------------
  localparam int P_NONE = 0, P_FLUSH = 1, P_DRAIN = 2, P_INIT = 3,
                 P_LOAD = 4, P_ACK = 5, P_DEAD = 6;

  int          phase;
  int          drained;
  bit          m_is_int, m_df, m_timed_out, m_valid;
  logic [7:0]  m_vec;
  logic [31:0] m_eip;
  logic        m_pe;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = P_NONE; drained = 0; m_is_int = 0; m_df = 0; m_timed_out = 0;
      m_vec = '0; m_eip = '0; m_pe = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (exc_req && phase >= P_FLUSH && phase <= P_LOAD) begin
        if (m_df) phase = P_DEAD;
        else begin
          m_vec = 8'd8; m_eip = exc_req_eip; m_pe = 1'b1;
          m_df = 1; m_is_int = 0; phase = P_FLUSH;
        end
      end else if (phase == P_NONE) begin
        if (exc_req) begin
          m_vec = exc_req_vector; m_eip = exc_req_eip; m_pe = exc_req_push_error;
          m_is_int = 0; phase = P_FLUSH;
        end else if (int_req && if_flag && !micro_busy) begin
          m_vec = int_vector; m_eip = int_eip; m_pe = 1'b0;
          m_is_int = 1; phase = P_FLUSH;
        end
      end else if (phase == P_FLUSH) begin
        drained = 0; phase = P_DRAIN;
      end else if (phase == P_DRAIN) begin
        drained++;
        if (!rd_busy) phase = P_INIT;
        else if (drained == DRAIN_TIMEOUT) begin m_timed_out = 1; phase = P_INIT; end
      end else if (phase == P_INIT) begin
        phase = P_LOAD;
      end else if (phase == P_LOAD) begin
        if (micro_ready) phase = P_ACK;
      end else if (phase == P_ACK) begin
        m_df = 0; phase = P_NONE;
      end
    end
  end

  function automatic logic [47:0] model_outs();
    return {phase == P_FLUSH, phase == P_INIT, phase == P_LOAD,
            (phase == P_ACK) && m_is_int, m_timed_out, phase == P_DEAD,
            phase != P_NONE, m_pe, m_vec, m_eip};
  endfunction

  always @(negedge clk) begin
    if (m_valid) check("cycle_outputs", outs(), model_outs());
  end

  task automatic wait_load();
    int n = 0;
    while (!exc_load && n < 200) begin tick(); n++; end
    check("wait_load", exc_load, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (seq_busy && n < 200) begin tick(); n++; end
    check("wait_idle", seq_busy, 0);
  endtask

  task automatic strobe_exc(input logic [7:0] v, input logic [31:0] e, input logic pe);
    exc_req = 1'b1; exc_req_vector = v; exc_req_eip = e; exc_req_push_error = pe;
    tick();
    exc_req = 1'b0;
  endtask

  initial begin
    int acks, resets, n;
    logic [7:0] loads[$];

    rst_n = 1'b0; exc_req = 0; exc_req_vector = '0; exc_req_eip = '0;
    exc_req_push_error = 0; int_req = 0; int_vector = '0; int_eip = '0;
    if_flag = 0; micro_busy = 0; rd_busy = 0; micro_ready = 1;
    repeat (3) tick();
    check("reset_outputs", outs(), 48'h0);
    rst_n = 1'b1;
    tick();

    // Simple exception: micro_reset T+1, exc_init T+3, exc_load T+4, idle T+6.
    strobe_exc(8'h0D, 32'h1234, 1'b0);
    check("simple_flush", {micro_reset, exc_init, exc_load}, 3'b100);
    tick();
    check("simple_drain", {micro_reset, exc_init, exc_load}, 3'b000);
    tick();
    check("simple_init", {micro_reset, exc_init, exc_load}, 3'b010);
    tick();
    check("simple_load", {exc_load, exc_eip, exc_vector}, {1'b1, 32'h1234, 8'h0D});
    tick();
    check("simple_ack", {int_ack, seq_busy}, 2'b01);
    tick();
    check("simple_idle", seq_busy, 0);

    // Interrupt, dropped after acceptance: still completes, one ack.
    int_req = 1; if_flag = 1; int_vector = 8'h20; int_eip = 32'h5000;
    tick();
    int_req = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (int_ack) acks++;
      if (exc_load) check("int_vector", exc_vector, 8'h20);
      tick();
    end
    check("int_ack_once", acks, 1);

    // Interrupts masked: never accepted.
    if_flag = 0; int_req = 1; resets = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (micro_reset) resets++; end
    check("masked_no_flush", resets, 0);
    int_req = 0; tick(); if_flag = 1;

    // Priority: exception first, pending interrupt right after.
    int_req = 1; int_vector = 8'h20;
    strobe_exc(8'h0D, 32'h4444, 1'b1);
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      if (exc_load) begin
        loads.push_back(exc_vector);
        if (loads.size() == 2) int_req = 0;
      end
      if (int_ack) acks++;
      tick();
    end
    check("prio_load_count", loads.size(), 2);
    if (loads.size() == 2) begin
      check("prio_first_vec", loads[0], 8'h0D);
      check("prio_second_vec", loads[1], 8'h20);
    end
    check("prio_ack_once", acks, 1);

    // Drain released after 5 busy cycles: no timeout.
    rd_busy = 1;
    strobe_exc(8'h0E, 32'hA0, 1'b0);
    n = 0;
    while (n < 200) begin
      tick(); n++;
      if (exc_init) break;
      if (n == 5) rd_busy = 0;
    end
    check("drain_short_len", n, 6);
    check("drain_short_no_to", drain_timeout, 0);
    rd_busy = 0;
    wait_idle();

    // Drain timeout: 64 DRAIN cycles then INIT, sticky flag set.
    rd_busy = 1;
    strobe_exc(8'h0E, 32'hA1, 1'b0);
    n = 0;
    while (n < 200) begin tick(); n++; if (exc_init) break; end
    check("drain_to_len", n, 65);
    check("drain_to_flag", drain_timeout, 1);
    rd_busy = 0;
    wait_idle();
    check("drain_to_sticky", drain_timeout, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("drain_to_cleared", drain_timeout, 0);

    // Escalation to double fault, then shutdown.
    micro_ready = 0;
    strobe_exc(8'h0E, 32'h1111, 1'b0);
    wait_load();
    strobe_exc(8'h33, 32'h2222, 1'b0);
    check("df_fields", {micro_reset, exc_push_error, exc_vector, exc_eip},
          {1'b1, 1'b1, 8'h08, 32'h2222});
    tick();
    strobe_exc(8'h44, 32'h3333, 1'b0);
    check("shutdown_set", {shutdown, seq_busy}, 2'b11);
    repeat (5) tick();
    check("shutdown_held", {shutdown, seq_busy, micro_reset, exc_init, exc_load}, 5'b11000);
    rst_n = 0; tick();
    check("shutdown_reset", outs(), 48'h0);
    rst_n = 1; tick();

    // LOAD hold: fields stable while micro_ready stays low, then reset.
    strobe_exc(8'h21, 32'hCAFE_0001, 1'b1);
    wait_load();
    for (int i = 0; i < 10; i++) begin
      check("load_hold", {exc_load, exc_eip, exc_vector, exc_push_error},
            {1'b1, 32'hCAFE_0001, 8'h21, 1'b1});
      tick();
    end
    rst_n = 0; tick();
    check("load_reset", outs(), 48'h0);
    rst_n = 1; micro_ready = 1; tick();

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      exc_req            = ($urandom_range(0, 99) < 6);
      exc_req_vector     = 8'($urandom);
      exc_req_eip        = $urandom;
      exc_req_push_error = 1'($urandom);
      if ($urandom_range(0, 9) == 0) int_req = ~int_req;
      int_vector  = 8'($urandom);
      int_eip     = $urandom;
      if_flag     = ($urandom_range(0, 9) != 0);
      micro_busy  = ($urandom_range(0, 3) == 0);
      rd_busy     = ((i % 700) < 90) ? 1'b1 : 1'($urandom);
      micro_ready = ($urandom_range(0, 2) == 0);
      rst_n       = ($urandom_range(0, 249) != 0);
      tick();
    end
    exc_req = 0; rst_n = 1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
